ml_dma_loader: RTL

- Upstream feeder for the dot-product accelerator. The CPU programs source addresses for vectors A and B, a destination address and a start bit.
- The block then, without further CPU involvement:
  - fetches 8 words from data memory and writes them into accelerator offsets 0x00-0x1C,
  - writes the accelerator control register (0x20),
  - waits for the accelerator's one-cycle done pulse,
  - reads the result (0x24) and stores it to memory,
  - raises a sticky done flag and an optional irq.
- While busy, the block owns the accelerator bus. The interconnect mux selects it when busy=1.

---
 rtl/ml_dma_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ml_dma_loader.sv
// DMA feeder for the dot-product accelerator: loads 8 operand words from memory,
// kicks the accelerator, waits for done and stores the result back to memory.
module ml_dma_loader #(
   parameter int TIMEOUT = 64,
   parameter int AW      = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          w_en,
   input  logic          r_en,
   input  logic [5:0]    addr,
   input  logic [31:0]   w_data,
   output logic [31:0]   r_data,
   output logic          irq,
   output logic          busy,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_ready,
   output logic          acc_w_en,
   output logic          acc_r_en,
   output logic [5:0]    acc_addr,
   output logic [31:0]   acc_w_data,
   input  logic [31:0]   acc_r_data,
   input  logic          acc_done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_PUSH  = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_READ  = 3'd5;
   localparam logic [2:0] S_STORE = 3'd6;
   localparam int         CW      = $clog2(TIMEOUT) + 1;

   logic [2:0]    state;
   logic [2:0]    idx;
   logic [AW-1:0] src_a, src_b, dst;
   logic          irq_en, done_flag, err_flag;
   logic [31:0]   result, word;
   logic [CW-1:0] cnt;
   logic          wr_ok, start;

   assign busy  = (state != S_IDLE);
   assign irq   = done_flag & irq_en;
   assign wr_ok = w_en && !busy;
   assign start = wr_ok && (addr == 6'h0C) && w_data[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         src_a     <= '0;
         src_b     <= '0;
         dst       <= '0;
         irq_en    <= 1'b0;
         done_flag <= 1'b0;
         err_flag  <= 1'b0;
         result    <= '0;
         word      <= '0;
         cnt       <= '0;
      end else begin
         if (wr_ok) begin
            case (addr)
               6'h00:   src_a  <= w_data[AW-1:0];
               6'h04:   src_b  <= w_data[AW-1:0];
               6'h08:   dst    <= w_data[AW-1:0];
               6'h0C:   irq_en <= w_data[1];
               default: ;
            endcase
         end
         // Flag clears come first so a set from the FSM below in the same cycle wins.
         if (w_en && addr == 6'h10) begin
            if (w_data[1]) done_flag <= 1'b0;
            if (w_data[2]) err_flag  <= 1'b0;
         end
         if (start) begin
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
         end

         case (state)
            S_IDLE: if (start) begin
               state <= S_FETCH;
               idx   <= '0;
            end
            S_FETCH: if (mem_ready) begin
               word  <= mem_rdata;
               state <= S_PUSH;
            end
            S_PUSH: begin
               idx   <= idx + 3'd1;
               state <= (idx == 3'd7) ? S_START : S_FETCH;
            end
            S_START: begin
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (acc_done) begin
                  state <= S_READ;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  err_flag <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_READ: begin
               result <= acc_r_data;
               state  <= S_STORE;
            end
            S_STORE: if (mem_ready) begin
               done_flag <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Bus outputs decode straight from state so reset silences them immediately.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      acc_w_en   = 1'b0;
      acc_r_en   = 1'b0;
      acc_addr   = '0;
      acc_w_data = '0;
      case (state)
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = (idx[2] ? src_b : src_a) + AW'({idx[1:0], 2'b00});
         end
         S_PUSH: begin
            acc_w_en   = 1'b1;
            acc_addr   = {1'b0, idx, 2'b00};
            acc_w_data = word;
         end
         S_START: begin
            acc_w_en   = 1'b1;
            acc_addr   = 6'h20;
            acc_w_data = 32'd1;
         end
         S_READ: begin
            acc_r_en = 1'b1;
            acc_addr = 6'h24;
         end
         S_STORE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = dst;
            mem_wdata = result;
         end
         default: ;
      endcase
   end

   always_comb begin
      r_data = '0;
      if (r_en) begin
         case (addr)
            6'h00:   r_data = 32'(src_a);
            6'h04:   r_data = 32'(src_b);
            6'h08:   r_data = 32'(dst);
            6'h0C:   r_data = {30'd0, irq_en, 1'b0};
            6'h10:   r_data = {29'd0, err_flag, done_flag, busy};
            6'h14:   r_data = result;
            default: r_data = '0;
         endcase
      end
   end

endmodule
